contador_ud_mod: RTL
====================

# contador_ud_mod

Parametrised up/down modulo counter with prescaled enable, synchronous clear/load and terminal-count cascade output. It succeeds the plain increment counter in the display-controller path. It drives digit-position scanning and BCD-style digit chains, where one instance's o_Tc feeds the next instance's i_En.

## Interface
- N, 8, counter width in bits.
- DIV, 1, prescaler ratio: count advances once per DIV enabled cycles (DIV=1 means every enabled cycle); DIV ≥ 1.
- WRAP, 1, 1 = modulo wrap at the ends, 0 = saturate at the ends.
- i_Clk  in  1  clock, rising edge.
- i_Rst  in  1  reset, asynchronous, active-low.
- i_En  in  1  count enable, fed to the prescaler.
- i_Up  in  1  direction: 1 = up, 0 = down.
- i_Clr  in  1  synchronous clear to 0.
- i_Load  in  1  synchronous load of i_Dato.
- i_Dato  in  N  load value.
- i_Mod  in  N  top value; the count range is 0..i_Mod.
- o_Cta  out  N  current count, registered.
- o_Tc  out  1  terminal count (combinational): tick & count at the end in the current direction.
- o_Wrap  out  1  registered one-cycle pulse when the count wrapped or saturated on the previous edge.
- i_Cmp  in  N  compare value (present only with CONTADOR_CMP_EN).
- o_Match  out  1  registered o_Cta==i_Cmp (present only with CONTADOR_CMP_EN).

## Operation
- **Reset:** while i_Rst=0, o_Cta=0, o_Wrap=0, o_Match=0 and the prescaler count is 0, independent of the clock.
- **tick:** i_En high on the cycle the prescaler count equals DIV-1.
  - The prescaler count increments only while i_En=1 and wraps to 0 on tick.
  - i_En=0 holds the prescaler count.
  - i_Clr or i_Load also clears the prescaler count.
- **Priority per edge:** i_Clr > i_Load > tick > hold.
- **Load:** o_Cta ← i_Dato if i_Dato ≤ i_Mod, else o_Cta ← i_Mod (clamped).
- **Up tick:**
  - If o_Cta ≥ i_Mod: WRAP=1 → 0 with wrap event; WRAP=0 → i_Mod with saturation event.
  - Otherwise o_Cta+1.
- **Down tick:**
  - If o_Cta == 0: WRAP=1 → i_Mod; WRAP=0 → 0. Both are wrap events.
  - If o_Cta > i_Mod (i_Mod lowered at runtime): → i_Mod, no wrap event.
  - Otherwise o_Cta-1.
- **Arithmetic:** all arithmetic is N bits unsigned. An internal N+1-bit compare is not needed; use ≥ against i_Mod.
- **i_Mod = 0:** o_Cta stays 0, and every tick is a wrap event (o_Tc=1 on every tick).
- **o_Tc:** tick & (i_Up ? o_Cta ≥ i_Mod : o_Cta == 0). It is also asserted in saturate mode.
- **o_Wrap:** set on the edge that performs a wrap/saturation event; cleared on the next edge unless another event occurs. Clr and Load never set it.
- **Reset mid-count:** all state returns to the reset values immediately. The first tick after release requires DIV enabled cycles.

## Timing
- o_Cta updates on the rising edge after inputs are sampled: 1-cycle latency from tick/Clr/Load.
- o_Tc is valid in the same cycle as the tick. It is combinational from the registered state plus i_En/i_Up, so it can be cascaded without added latency.
- o_Wrap is high for exactly one cycle, aligned with the first cycle o_Cta shows the wrapped/saturated value.
- o_Match is registered from the next o_Cta value, so it is aligned with o_Cta (no extra lag).
- Changes on i_Up or i_Mod take effect on the next edge; there is no pipeline.

## Configuration
- **CONTADOR_CMP_EN defined:** adds the i_Cmp port and the o_Match register. o_Match = 1 on every cycle where o_Cta == i_Cmp (registered alongside o_Cta); reset value 0.
- **CONTADOR_CMP_EN not defined:** i_Cmp and o_Match do not exist and no compare logic is generated. All other behaviour is identical.

## Structure
- **Shared package contador_pkg:**
  - direction constants DIR_UP=1, DIR_DOWN=0;
  - mode constants MODE_WRAP=1, MODE_SAT=0;
  - a clog2 function for sizing the prescaler counter.
- **One sub-module, prescaler_tick:**
  - parameter DIV; inputs i_Clk, i_Rst, i_En, i_Sync_Clr; output o_Tick.
  - It holds a clog2(DIV)-bit counter; for DIV=1 it degenerates to o_Tick = i_En.
- The top level contains the count register, next-value mux, o_Tc and o_Wrap logic, and the optional compare.

## Test plan
All scenarios use N=4 unless noted.
1. **Decimal wrap:** DIV=1, WRAP=1, i_Mod=9, i_Up=1, i_En=1 for 12 cycles from reset → o_Cta 1..9,0,1,2; o_Tc high on the cycle o_Cta=9; o_Wrap high only the cycle o_Cta=0.
2. **Down count with clamped load:** i_Up=0, i_Mod=9, i_Load with i_Dato=12 → o_Cta=9; then ticks → 8,7,…,0,9 with o_Wrap at 9.
3. **Saturation:** WRAP=0, i_Mod=5, up from 4 → 5,5,5; o_Tc=1 on each tick at 5; o_Wrap pulses on each saturating tick.
4. **Prescaler:** DIV=3, i_En=1 continuously → o_Cta increments every 3rd cycle; dropping i_En for 2 cycles mid-period delays the next increment by exactly 2 cycles.
5. **Priority and reset:** i_Clr and i_Load asserted together at o_Cta=7 → 0. Asserting i_Rst=0 between clock edges at o_Cta=6 → o_Cta=0 immediately, with o_Wrap and o_Match at 0.
6. **Compare:** CONTADOR_CMP_EN defined, i_Cmp=3 → o_Match high exactly while o_Cta=3. Runtime lowering of i_Mod from 9 to 4 at o_Cta=7 with i_Up=1 → next tick gives o_Cta=0 with o_Wrap=1.

Source files
------------

// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared constants and sizing helper for the up/down modulo counter
package contador_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;
    localparam logic MODE_SAT  = 1'b0;

    // Bits needed to hold 0..value-1; 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/prescaler_tick.sv
// rtl/prescaler_tick.sv - divides enabled cycles by DIV into a one-cycle tick
module prescaler_tick
    import contador_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_En,
    input  logic i_Sync_Clr,
    output logic o_Tick
);

    generate
        if (DIV <= 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = &{1'b0, i_Clk, i_Rst, i_Sync_Clr};
            assign o_Tick        = i_En;
        end else begin : g_div
            localparam int W = clog2(DIV);
            localparam logic [W-1:0] LAST = W'(DIV - 1);

            logic [W-1:0] count;

            assign o_Tick = i_En && (count == LAST);

            // The count only moves on enabled cycles, so gaps in i_En stretch the period.
            always_ff @(posedge i_Clk or negedge i_Rst) begin
                if (!i_Rst) begin
                    count <= '0;
                end else if (i_Sync_Clr) begin
                    count <= '0;
                end else if (i_En) begin
                    count <= o_Tick ? '0 : count + W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/contador_ud_mod.sv
// rtl/contador_ud_mod.sv - up/down modulo counter with prescaled tick; CONTADOR_CMP_EN adds i_Cmp/o_Match
module contador_ud_mod
    import contador_pkg::*;
#(
    parameter int N    = 8,
    parameter int DIV  = 1,
    parameter bit WRAP = 1'b1
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_En,
    input  logic         i_Up,
    input  logic         i_Clr,
    input  logic         i_Load,
    input  logic [N-1:0] i_Dato,
    input  logic [N-1:0] i_Mod,
`ifdef CONTADOR_CMP_EN
    input  logic [N-1:0] i_Cmp,
    output logic         o_Match,
`endif
    output logic [N-1:0] o_Cta,
    output logic         o_Tc,
    output logic         o_Wrap
);

    logic         tick;
    logic         at_top;
    logic         at_zero;
    logic         wrap_evt;
    logic [N-1:0] cta_nxt;

    prescaler_tick #(
        .DIV(DIV)
    ) u_prescaler (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_En      (i_En),
        .i_Sync_Clr(i_Clr | i_Load),
        .o_Tick    (tick)
    );

    // at_top also covers a count left above a lowered i_Mod.
    assign at_top  = (o_Cta >= i_Mod);
    assign at_zero = (o_Cta == '0);
    assign o_Tc    = tick && ((i_Up == DIR_UP) ? at_top : at_zero);

    always_comb begin
        cta_nxt  = o_Cta;
        wrap_evt = 1'b0;
        if (i_Clr) begin
            cta_nxt = '0;
        end else if (i_Load) begin
            cta_nxt = (i_Dato <= i_Mod) ? i_Dato : i_Mod;
        end else if (tick && (i_Up == DIR_UP)) begin
            if (at_top) begin
                wrap_evt = 1'b1;
                cta_nxt  = (WRAP == MODE_WRAP) ? '0 : i_Mod;
            end else begin
                cta_nxt = o_Cta + N'(1);
            end
        end else if (tick && (i_Up == DIR_DOWN)) begin
            if (at_zero) begin
                wrap_evt = 1'b1;
                cta_nxt  = (WRAP == MODE_SAT) ? '0 : i_Mod;
            end else if (o_Cta > i_Mod) begin
                cta_nxt = i_Mod;
            end else begin
                cta_nxt = o_Cta - N'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            o_Cta  <= '0;
            o_Wrap <= 1'b0;
        end else begin
            o_Cta  <= cta_nxt;
            o_Wrap <= wrap_evt;
        end
    end

`ifdef CONTADOR_CMP_EN
    // Compare against the next value so o_Match lines up with o_Cta.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            o_Match <= 1'b0;
        end else begin
            o_Match <= (cta_nxt == i_Cmp);
        end
    end
`endif

endmodule
